addr_mux_bus: RTL and testbench
===============================

ADDR_MUX_BUS -- requirements
Module: addr_mux_bus

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, full address width from the core.
REQ-002 SHALL have parameter PIN_W, default 8, external address pin width; ADDR_W SHALL be an integer multiple of PIN_W (elaboration error otherwise).
REQ-003 SHALL have parameter DATA_W, default 8, data pin width.
REQ-004 SHALL have parameter WAIT_STATES, default 0, minimum wait cycles between address and data phases.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  core requests a transfer.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  transfer address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_ready  output  1  transfer accepted when req_valid and req_ready are high on the same edge.
REQ-012 ext_rdy  input  1  external ready; low stretches wait and data phases.
REQ-013 data_in  input  DATA_W  external read data pins.
REQ-014 addr_pins  output  PIN_W  multiplexed address slice.
REQ-015 addr_phase  output  max(1,clog2(ADDR_W/PIN_W))  index of slice on addr_pins.
REQ-016 addr_valid  output  1  addr_pins carry a valid slice.
REQ-017 data_out  output  DATA_W  write data pins.
REQ-018 data_oe  output  DATA_W  per-bit output enable, all ones during write data phase, else zero.
REQ-019 rw  output  1  1 = read, 0 = write (6502 convention).
REQ-020 rsp_valid  output  1  one-cycle completion pulse.
REQ-021 rsp_rdata  output  DATA_W  captured read data, valid with rsp_valid on reads, held until next capture.

Function
REQ-022 SHALL implement states IDLE, ADDR, WAIT, DATA, DONE; all outputs registered.
REQ-023 req_ready SHALL be 1 only in IDLE; acceptance latches req_we/req_addr/req_wdata and moves to ADDR.
REQ-024 ADDR SHALL last N = ADDR_W/PIN_W cycles, slice k = req_addr[k*PIN_W +: PIN_W] in cycle k, least-significant slice first, addr_phase = k, addr_valid = 1.
REQ-025 After last slice, WAIT SHALL last WAIT_STATES cycles (skipped when 0), extended while ext_rdy = 0.
REQ-026 DATA SHALL last one cycle if ext_rdy = 1, held while ext_rdy = 0; write: data_out = wdata, data_oe all ones, rw = 0; read: data_in captured into rsp_rdata on the DATA cycle's exit edge.
REQ-027 rw SHALL equal latched ~req_we from first ADDR cycle until DONE, 1 otherwise.
REQ-028 DONE SHALL last one cycle with rsp_valid = 1, then IDLE.
REQ-029 Unstalled latency from acceptance edge to rsp_valid high SHALL be N + WAIT_STATES + 2 cycles; for 16/8/0 that is 4 cycles, throughput one transfer per 5 cycles.
REQ-030 In IDLE/DONE addr_pins SHALL be 0, addr_valid 0, data_oe 0, data_out 0.
REQ-031 Request inputs SHALL be ignored outside IDLE; changes mid-transfer SHALL not affect the transfer.
REQ-032 ext_rdy SHALL be ignored in ADDR and DONE.
REQ-033 data_oe SHALL never be nonzero while rw = 1.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, addr_pins 0, addr_phase 0, addr_valid 0, data_out 0, data_oe 0, rw 1, rsp_valid 0, rsp_rdata 0, req_ready 0.
REQ-035 req_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-036 Reset mid-transfer SHALL abort without rsp_valid; the aborted transfer is lost.

Structure
REQ-037 Shared package bus_pkg SHALL hold the state enum and a constant function computing N and addr_phase width.
REQ-038 One sub-module, bus_wait_counter, SHALL count WAIT_STATES with ext_rdy stretch and flag done.

Verification
REQ-039 Defaults, read addr 0x1234, data_in 0xA5 -> addr_pins 0x34 (phase 0), 0x12 (phase 1), rw=1, rsp_valid 4 cycles after accept, rsp_rdata 0xA5.
REQ-040 Write 0xBEEF data 0x5A -> slices 0xEF,0xBE, DATA cycle data_out 0x5A, data_oe 0xFF, rw 0; data_oe 0 all other cycles.
REQ-041 WAIT_STATES=2, ext_rdy low 3 cycles entering DATA -> rsp_valid 4+2+3 = 9 cycles after accept; data_in sampled only on ext_rdy-high exit.
REQ-042 ADDR_W=24, PIN_W=8, addr 0xABCDEF -> slices 0xEF,0xCD,0xAB, phases 0,1,2, rsp_valid 5 cycles after accept.
REQ-043 rst_n low during write DATA -> data_oe 0 and rw 1 without clock edge; no rsp_valid; req_ready 1 first edge after release.
REQ-044 req_valid held high continuously -> back-to-back accepts every 5 cycles, req_ready high only in IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and sizing helpers for the multiplexed address bus.
package bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_DATA,
      S_DONE
   } state_t;

   function automatic int slice_cnt(input int addr_w, input int pin_w);
      return addr_w / pin_w;
   endfunction

   // A single-slice bus still exposes a one-bit phase index.
   function automatic int phase_w(input int addr_w, input int pin_w);
      int n;
      n = addr_w / pin_w;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Counts ext_rdy-high cycles in the wait phase; low cycles stretch it.
module bus_wait_counter #(
   parameter int WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_rdy,
   output logic o_done
);

   localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES);
   localparam logic [CW-1:0] LAST = CW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   logic [CW-1:0] r_cnt;

   assign o_done = i_en && i_rdy && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (o_done) begin
         r_cnt <= '0;
      end else if (i_en && i_rdy) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/addr_mux_bus.sv
// Core-to-pin bridge: address sent as PIN_W slices, then wait and data phases.
module addr_mux_bus
   import bus_pkg::*;
#(
   parameter int  ADDR_W      = 16,
   parameter int  PIN_W       = 8,
   parameter int  DATA_W      = 8,
   parameter int  WAIT_STATES = 0,
   localparam int PH_W        = phase_w(ADDR_W, PIN_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   input  logic              ext_rdy,
   input  logic [DATA_W-1:0] data_in,
   output logic [PIN_W-1:0]  addr_pins,
   output logic [PH_W-1:0]   addr_phase,
   output logic              addr_valid,
   output logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] data_oe,
   output logic              rw,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata
);

   localparam int N = slice_cnt(ADDR_W, PIN_W);
   localparam logic [PH_W-1:0] LAST_PH = PH_W'(N - 1);

   if (ADDR_W % PIN_W != 0) begin : g_bad_width
      $error("ADDR_W must be an integer multiple of PIN_W");
   end

   state_t            r_state, w_nxt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_req_ready, r_addr_valid, r_rw, r_rsp_valid;
   logic [PIN_W-1:0]  r_addr_pins;
   logic [PH_W-1:0]   r_addr_phase, w_phase;
   logic [DATA_W-1:0] r_data_out, r_data_oe, r_rsp_rdata;
   logic              w_acc, w_we, w_wait_done, w_wr_data;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   // Outputs are registered from next state, so on acceptance use live inputs.
   assign w_acc     = req_valid && r_req_ready;
   assign w_we      = w_acc ? req_we    : r_we;
   assign w_addr    = w_acc ? req_addr  : r_addr;
   assign w_wdata   = w_acc ? req_wdata : r_wdata;
   assign w_wr_data = (w_nxt == S_DATA) && w_we;

   bus_wait_counter #(
      .WAIT_STATES(WAIT_STATES)
   ) u_wait (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (r_state == S_WAIT),
      .i_rdy (ext_rdy),
      .o_done(w_wait_done)
   );

   always_comb begin
      w_nxt   = r_state;
      w_phase = r_addr_phase;
      unique case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               w_nxt   = S_ADDR;
               w_phase = '0;
            end
         end
         S_ADDR: begin
            if (r_addr_phase == LAST_PH) begin
               w_phase = '0;
               w_nxt   = (WAIT_STATES == 0) ? S_DATA : S_WAIT;
            end else begin
               w_phase = r_addr_phase + 1'b1;
            end
         end
         S_WAIT: if (w_wait_done) w_nxt = S_DATA;
         S_DATA: if (ext_rdy) w_nxt = S_DONE;
         S_DONE: w_nxt = S_IDLE;
         default: begin
            w_nxt   = S_IDLE;
            w_phase = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b0;
         r_addr_valid <= 1'b0;
         r_addr_phase <= '0;
         r_addr_pins  <= '0;
         r_rw         <= 1'b1;
         r_data_oe    <= '0;
         r_data_out   <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_acc) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         r_req_ready  <= (w_nxt == S_IDLE);
         r_addr_valid <= (w_nxt == S_ADDR);
         r_addr_phase <= w_phase;
         r_addr_pins  <= (w_nxt == S_ADDR) ?
                         PIN_W'(w_addr >> (PIN_W * int'(w_phase))) : '0;
         r_rw         <= (w_nxt inside {S_ADDR, S_WAIT, S_DATA}) ? ~w_we : 1'b1;
         r_data_oe    <= w_wr_data ? '1 : '0;
         r_data_out   <= w_wr_data ? w_wdata : '0;
         r_rsp_valid  <= (w_nxt == S_DONE);
         if (r_state == S_DATA && ext_rdy && !r_we) begin
            r_rsp_rdata <= data_in;
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign addr_pins  = r_addr_pins;
   assign addr_phase = r_addr_phase;
   assign addr_valid = r_addr_valid;
   assign data_out   = r_data_out;
   assign data_oe    = r_data_oe;
   assign rw         = r_rw;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_addr_mux_bus.sv
// Bench: three bus configurations checked cycle by cycle against a phase model.
module tb_addr_mux_bus;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [23:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        ext_rdy = 1'b1;
   logic [7:0]  data_in = '0;
   int          sel = 0;

   logic        vin [3];
   logic        rr [3], av [3], rwv [3], rv [3];
   logic [7:0]  pins [3], oe [3], dout [3], rd [3];
   logic        ph0, ph1;
   logic [1:0]  ph2, phx;
   logic [37:0] o_obs;
   logic [7:0]  last_rd [3];

   int n_chk = 0;
   int n_pass = 0;
   time acc_t;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 3; i++) vin[i] = req_valid && (sel == i);
      phx = (sel == 0) ? {1'b0, ph0} : (sel == 1) ? {1'b0, ph1} : ph2;
      o_obs = {rr[sel], av[sel], phx, pins[sel], rwv[sel], oe[sel],
               dout[sel], rv[sel], rd[sel]};
   end

   addr_mux_bus u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(vin[0]), .req_we(req_we),
      .req_addr(req_addr[15:0]), .req_wdata(req_wdata), .req_ready(rr[0]),
      .ext_rdy(ext_rdy), .data_in(data_in), .addr_pins(pins[0]),
      .addr_phase(ph0), .addr_valid(av[0]), .data_out(dout[0]),
      .data_oe(oe[0]), .rw(rwv[0]), .rsp_valid(rv[0]), .rsp_rdata(rd[0])
   );

   addr_mux_bus #(.WAIT_STATES(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(vin[1]), .req_we(req_we),
      .req_addr(req_addr[15:0]), .req_wdata(req_wdata), .req_ready(rr[1]),
      .ext_rdy(ext_rdy), .data_in(data_in), .addr_pins(pins[1]),
      .addr_phase(ph1), .addr_valid(av[1]), .data_out(dout[1]),
      .data_oe(oe[1]), .rw(rwv[1]), .rsp_valid(rv[1]), .rsp_rdata(rd[1])
   );

   addr_mux_bus #(.ADDR_W(24)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(vin[2]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rr[2]),
      .ext_rdy(ext_rdy), .data_in(data_in), .addr_pins(pins[2]),
      .addr_phase(ph2), .addr_valid(av[2]), .data_out(dout[2]),
      .data_oe(oe[2]), .rw(rwv[2]), .rsp_valid(rv[2]), .rsp_rdata(rd[2])
   );

   function automatic int nsl(input int s);
      return (s == 2) ? 3 : 2;
   endfunction

   function automatic int wst(input int s);
      return (s == 1) ? 2 : 0;
   endfunction

   function automatic logic [37:0] mk(
      input logic r_o, input logic a_o, input logic [1:0] p_o,
      input logic [7:0] pin_o, input logic rw_o, input logic [7:0] oe_o,
      input logic [7:0] do_o, input logic v_o, input logic [7:0] rd_o);
      return {r_o, a_o, p_o, pin_o, rw_o, oe_o, do_o, v_o, rd_o};
   endfunction

   // mode 0: ext_rdy high; 1: random stalls; 2: low 3 cycles entering DATA.
   task automatic run_xfer(input bit we, input logic [23:0] addr,
                           input logic [7:0] wd, input int mode,
                           input bit b2b, input string tag);
      int n, w, m, ds, h;
      bit rdy [1:64];
      logic [7:0] din [1:64];
      logic [37:0] e;
      logic [7:0] e_rd;
      n = nsl(sel);
      w = wst(sel);
      for (int k = 1; k <= 64; k++) begin
         din[k] = 8'($urandom);
         if (k <= n) rdy[k] = 1'($urandom);
         else if (mode == 1 && k <= 40) rdy[k] = ($urandom_range(0, 2) != 0);
         else if (mode == 2) rdy[k] = !(k > n + w && k <= n + w + 3);
         else rdy[k] = 1'b1;
      end
      // After the address slices, the transfer consumes w+1 ready cycles.
      h = 0; ds = 0; m = 0;
      for (int k = n + 1; k <= 64; k++) begin
         if (ds == 0 && h >= w) ds = k;
         if (rdy[k]) h++;
         if (m == 0 && h == w + 1) m = k;
      end
      @(negedge clk);
      e = mk(1, 0, 0, 0, 1, 0, 0, 0, last_rd[sel]);
      n_chk++;
      if (o_obs !== e)
         $display("FAIL %s idle: got %h want %h", tag, o_obs, e);
      else n_pass++;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      acc_t = $time;
      e_rd = we ? last_rd[sel] : din[m];
      for (int k = 1; k <= m + 1; k++) begin
         @(negedge clk);
         if (k <= n)
            e = mk(0, 1, 2'(k - 1), 8'(addr >> (8 * (k - 1))), ~we, 0, 0, 0,
                   last_rd[sel]);
         else if (k <= m && k >= ds && we)
            e = mk(0, 0, 0, 0, 1'b0, 8'hFF, wd, 0, last_rd[sel]);
         else if (k <= m)
            e = mk(0, 0, 0, 0, ~we, 0, 0, 0, last_rd[sel]);
         else
            e = mk(0, 0, 0, 0, 1, 0, 0, 1, e_rd);
         n_chk++;
         if (o_obs !== e)
            $display("FAIL %s cycle %0d: got %h want %h", tag, k, o_obs, e);
         else n_pass++;
         if (k <= 64) begin
            ext_rdy = rdy[k];
            data_in = din[k];
         end
         req_we = 1'($urandom); req_addr = 24'($urandom);
         req_wdata = 8'($urandom);
         if (!b2b) req_valid = (k <= m) ? 1'($urandom) : 1'b0;
      end
      last_rd[sel] = e_rd;
   endtask

   task automatic test_reset();
      logic [37:0] e;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      e = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_chk++;
         if (o_obs !== e)
            $display("FAIL reset dut%0d: got %h want %h", s, o_obs, e);
         else n_pass++;
         last_rd[s] = 8'h00;
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (rr[0] !== 1'b0) $display("FAIL ready_pre_edge: got %b want 0", rr[0]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (rr[0] !== 1'b1) $display("FAIL ready_first_edge: got %b want 1", rr[0]);
      else n_pass++;
   endtask

   task automatic test_read_basic();
      sel = 0;
      run_xfer(1'b0, 24'h001234, 8'h00, 0, 1'b0, "read_1234");
   endtask

   task automatic test_write_basic();
      sel = 0;
      run_xfer(1'b1, 24'h00BEEF, 8'h5A, 0, 1'b0, "write_beef");
   endtask

   task automatic test_wait_stall();
      sel = 1;
      run_xfer(1'b0, 24'($urandom), 8'h00, 2, 1'b0, "wait2_stall_rd");
      run_xfer(1'b1, 24'($urandom), 8'($urandom), 2, 1'b0, "wait2_stall_wr");
      run_xfer(1'b0, 24'($urandom), 8'h00, 0, 1'b0, "wait2_nostall");
   endtask

   task automatic test_wide_addr();
      sel = 2;
      run_xfer(1'b0, 24'hABCDEF, 8'h00, 0, 1'b0, "addr24_rd");
      run_xfer(1'b1, 24'hABCDEF, 8'h77, 0, 1'b0, "addr24_wr");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         sel = i % 3;
         run_xfer(1'($urandom), 24'($urandom), 8'($urandom),
                  $urandom_range(0, 1), 1'b0, "random");
      end
   endtask

   task automatic test_back_to_back();
      time prev;
      sel = 0;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         run_xfer(1'($urandom), 24'($urandom), 8'($urandom), 0, 1'b1, "b2b");
         if (i > 0) begin
            n_chk++;
            if (acc_t - prev !== 50)
               $display("FAIL b2b_interval: got %0t want 50", acc_t - prev);
            else n_pass++;
         end
         prev = acc_t;
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset_mid_xfer();
      logic [37:0] e;
      sel = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 24'($urandom);
      req_wdata = 8'h3C; ext_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({oe[0], rwv[0]} !== {8'hFF, 1'b0})
         $display("FAIL mid_data_phase: got %h want 1fe", {oe[0], rwv[0]});
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      e = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
      n_chk++;
      if (o_obs !== e) $display("FAIL async_reset: got %h want %h", o_obs, e);
      else n_pass++;
      for (int s = 0; s < 3; s++) last_rd[s] = 8'h00;
      @(negedge clk);
      n_chk++;
      if (o_obs !== e) $display("FAIL reset_hold: got %h want %h", o_obs, e);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      e = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
      n_chk++;
      if (o_obs !== e) $display("FAIL reset_release: got %h want %h", o_obs, e);
      else n_pass++;
      run_xfer(1'b0, 24'($urandom), 8'h00, 1, 1'b0, "after_reset");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_basic();
      test_write_basic();
      test_wait_stall();
      test_wide_addr();
      test_random();
      test_back_to_back();
      test_reset_mid_xfer();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
